// File: rtl/seg_scan_mux.sv
// seg_scan_mux: shows a multi-digit BCD shadow register one digit at a time, for a 7-segment decoder.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to store leading zeros as blank (4'hF) at capture.
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              data,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [3:0]            shadow_q [NUM_DIGITS];
    logic [3:0]            shadow_d [NUM_DIGITS];
    logic [3:0]            bcd_fmt [NUM_DIGITS];
    logic [3:0]            data_q, data_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  ack_q, fs_q;
    logic                  tick, wrap, capture;

    assign tick    = en && (presc_q == PRESC_LAST);
    assign wrap    = tick && (idx_q == IDX_LAST);
    assign capture = wrap && (pending_q || load);

    // Format incoming digits as they will be stored in the shadow register.
    always_comb begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        logic lz;
        lz = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            bcd_fmt[i] = bcd_in[4*i +: 4];
            lz = lz && (bcd_in[4*i +: 4] == 4'd0);
            if (i > 0 && lz) begin
                bcd_fmt[i] = 4'hF;
            end
        end
`else
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            bcd_fmt[i] = bcd_in[4*i +: 4];
        end
`endif
    end

    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        onehot    = '0;
        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            if (capture) begin
                pending_d = 1'b0;
            end else if (load) begin
                pending_d = 1'b1;
            end
        end
        if (capture) begin
            shadow_d = bcd_fmt;
        end
        // Outputs follow the post-edge index so data and dig_sel move together with idx.
        onehot[idx_d] = 1'b1;
        data_d = en ? shadow_d[idx_d] : 4'hF;
        sel_d  = en ? (onehot ^ SEL_OFF) : SEL_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '{default: 4'hF};
            data_q    <= 4'hF;
            sel_q     <= SEL_OFF;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            ack_q     <= capture;
            fs_q      <= wrap;
        end
    end

    assign data        = data_q;
    assign dig_sel     = sel_q;
    assign load_ack    = ack_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: each new (data, dig_sel) presentation is popped and compared,
// including its dwell time and the load_ack / frame_start flags on its first cycle.
module tb_seg_scan_mux;

    typedef struct {
        logic [3:0] data;
        logic [3:0] sel;
        logic       ack;
        logic       fs;
        int         len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'hFFFF;
    logic        load_ack;
    logic [3:0]  data;
    logic [3:0]  dig_sel;
    logic        frame_start;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acks_seen = 0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    seg_scan_mux #(
        .NUM_DIGITS    (4),
        .SCAN_DIV      (4),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bcd_in     (bcd_in),
        .load       (load),
        .load_ack   (load_ack),
        .data       (data),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] s, input logic a, input logic f,
                        input int l);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.ack  = a;
        e.fs   = f;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    // Advance at least one negedge, then until the chosen pulse is seen (0: frame_start, 1: load_ack).
    task automatic wait_pulse(input int which, input string name);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? frame_start : load_ack;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no pulse in 200 cycles, expected a pulse", name);
        end
    endtask

    initial begin : monitor
        exp_t       cur;
        logic [7:0] prev;
        logic       have_prev;
        int         run_len;
        cur.len   = 0;
        prev      = '0;
        have_prev = 1'b0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (load_ack) acks_seen++;
            if (!have_prev || {data, dig_sel} !== prev) begin
                if (have_prev && cur.len != 0) chk("dwell", 32'(run_len), 32'(cur.len));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_presentation: got data=%h dig_sel=%b, expected none",
                             data, dig_sel);
                    cur.len = 0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("data", 32'(data), 32'(cur.data));
                    chk("dig_sel", 32'(dig_sel), 32'(cur.sel));
                    chk("load_ack", 32'(load_ack), 32'(cur.ack));
                    chk("frame_start", 32'(frame_start), 32'(cur.fs));
                end
                prev      = {data, dig_sel};
                have_prev = 1'b1;
                run_len   = 1;
            end else begin
                run_len++;
                chk("no_midpulse", 32'({load_ack, frame_start}), 32'd0);
            end
        end
    end

    initial begin : driver
        // 1: reset, then first frame of blanks (digit 0 dwells 3 cycles from a zeroed prescaler).
        push(4'hF, 4'b1111, 1'b0, 1'b0, 0);
        push(4'hF, 4'b1110, 1'b0, 1'b0, 3);
        push(4'hF, 4'b1101, 1'b0, 1'b0, 4);
        push(4'hF, 4'b1011, 1'b0, 1'b0, 4);
        push(4'hF, 4'b0111, 1'b0, 1'b0, 4);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 2: single load pulse mid-frame, captured at the next wrap.
        repeat (5) @(negedge clk);
        push(4'h4, 4'b1110, 1'b1, 1'b1, 4);
        push(4'h3, 4'b1101, 1'b0, 1'b0, 4);
        push(4'h2, 4'b1011, 1'b0, 1'b0, 4);
        push(4'h1, 4'b0111, 1'b0, 1'b0, 4);
        push(4'h4, 4'b1110, 1'b0, 1'b1, 4);
        push(4'h3, 4'b1101, 1'b0, 1'b0, 4);
        push(4'h2, 4'b1011, 1'b0, 1'b0, 4);
        push(4'h1, 4'b0111, 1'b0, 1'b0, 4);
        bcd_in = 16'h1234;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_pulse(1, "ack_1234");

        // 3: load held 3 cycles merges into one capture.
        wait_pulse(0, "frame2");
        push(4'h8, 4'b1110, 1'b1, 1'b1, 4);
        push(4'h7, 4'b1101, 1'b0, 1'b0, 4);
        bcd_in = 16'h5678;
        load   = 1'b1;
        repeat (3) @(negedge clk);
        load = 1'b0;
        wait_pulse(1, "ack_5678");

        // 4: drop en after the edge leaving idx=2, prescaler=1; digit 3 comes 3 edges after re-enable.
        push(4'h6, 4'b1011, 1'b0, 1'b0, 2);
        push(4'hF, 4'b1111, 1'b0, 1'b0, 5);
        push(4'h6, 4'b1011, 1'b0, 1'b0, 2);
        push(4'h5, 4'b0111, 1'b0, 1'b0, 4);
        push(4'h8, 4'b1110, 1'b0, 1'b1, 0);
        repeat (9) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;

        // 5: async reset between edges with a load pending; the load is discarded.
        wait_pulse(0, "frame4");
        push(4'hF, 4'b1111, 1'b0, 1'b0, 0);
        push(4'hF, 4'b1110, 1'b0, 1'b0, 3);
        push(4'hF, 4'b1101, 1'b0, 1'b0, 4);
        push(4'hF, 4'b1011, 1'b0, 1'b0, 4);
        push(4'hF, 4'b0111, 1'b0, 1'b0, 4);
        push(4'hF, 4'b1110, 1'b0, 1'b1, 4);
        @(negedge clk);
        bcd_in = 16'h9999;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data), 32'hF);
        chk("async_rst_dig_sel", 32'(dig_sel), 32'hF);
        chk("async_rst_load_ack", 32'(load_ack), 32'd0);
        chk("async_rst_frame_start", 32'(frame_start), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 6: leading-zero handling of 16'h0040.
        wait_pulse(0, "frame_after_reset");
        push(4'hF, 4'b1101, 1'b0, 1'b0, 4);
        push(4'hF, 4'b1011, 1'b0, 1'b0, 4);
        push(4'hF, 4'b0111, 1'b0, 1'b0, 4);
        push(4'h0, 4'b1110, 1'b1, 1'b1, 4);
        push(4'h4, 4'b1101, 1'b0, 1'b0, 4);
        push(LZ,   4'b1011, 1'b0, 1'b0, 4);
        push(LZ,   4'b0111, 1'b0, 1'b0, 4);
        push(4'h0, 4'b1110, 1'b0, 1'b1, 0);
        bcd_in = 16'h0040;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_pulse(1, "ack_0040");
        wait_pulse(0, "final_frame");
        @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ack_count", 32'(acks_seen), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
